// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 mux with a round-robin / fixed-priority
// arbiter and valid/ready handshakes on every input and on the output.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   fixed_pri  0 = round-robin from ptr, 1 = lowest index wins
//   in_valid   per-channel request
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_ready   one-hot (or zero) accept back to the granted channel
//   out_valid  output register holds a word
//   out_data   registered word from the winning channel
//   out_src    index of the channel that supplied out_data
//   out_ready  downstream takes out_data this cycle
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fixed_pri,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] g;
  logic             gnt;
  logic [WIDTH-1:0] g_data;
  logic             load_en;
  logic             xfer;

  // Register is free, or its word leaves this same cycle.
  assign load_en = ~out_valid | out_ready;
  assign xfer    = gnt & load_en & ~reset;

  // Walk the channels starting at ptr (or at 0 in fixed mode) and take
  // the first valid one. Only the winner's data is ever read, so
  // garbage on idle channels cannot reach the output register.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = 1'b0;
    g      = '0;
    g_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = fixed_pri ? k : int'(ptr) + k;
      if (idx >= CHANNELS)
        idx = idx - CHANNELS;
      if (!gnt && in_valid[idx]) begin
        gnt    = 1'b1;
        g      = SEL_W'(idx);
        g_data = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer)
      in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_src   <= g;
      if (!fixed_pri)
        ptr <= (g == SEL_W'(CHANNELS-1)) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed plus random checks of rr_arb_mux against a
// behavioural arbiter model held in the bench.
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int C = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           fixed_pri;
  logic [C-1:0]   in_valid;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;
  logic           out_ready;

  int tests = 0;
  int fails = 0;

  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_src;
  int         m_ptr;

  rr_arb_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .fixed_pri(fixed_pri),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Winner per the rules: first valid channel in the order
  // ptr, ptr+1, ... (mod C), or 0, 1, ... in fixed mode; -1 if none.
  function automatic int m_grant();
    int start;
    start = fixed_pri ? 0 : m_ptr;
    for (int k = 0; k < C; k++)
      if (in_valid[(start + k) % C])
        return (start + k) % C;
    return -1;
  endfunction

  function automatic logic [C-1:0] m_ready();
    int g;
    g = m_grant();
    if (reset || g < 0 || !(!m_valid || out_ready))
      return '0;
    return C'(1) << g;
  endfunction

  // One clock: compare everything on the falling edge, then advance
  // the model across the rising edge.
  task automatic tick();
    int  g;
    bit  ld;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_src", 32'(out_src), 32'(m_src));
    g  = m_grant();
    ld = !m_valid || out_ready;
    if (reset) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (g >= 0 && ld) begin
      m_valid = 1;
      m_data  = in_data[g*W +: W];
      m_src   = g;
      if (!fixed_pri) m_ptr = (g + 1) % C;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_data();
    for (int i = 0; i < C; i++)
      in_data[i*W +: W] = 32'hA000_0000 | 32'(i);
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    reset = 1; fixed_pri = 0; out_ready = 1;
    in_valid = 4'b1111;
    set_a_data();

    // reset with everything requesting
    #1;
    chk("rst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("rst_rdy2", 32'(in_ready), 32'h0);
    tick();
    chk("rst_oval", 32'(out_valid), 32'h0);
    chk("rst_odat", out_data, 32'h0);
    reset = 0;
    #1;
    chk("first_gnt", 32'(in_ready), 32'h1);

    // round-robin sweep 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      chk("rr_rdy", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      chk("rr_src", 32'(out_src), 32'(i % 4));
      chk("rr_dat", out_data, 32'hA000_0000 | 32'(i % 4));
      chk("rr_val", 32'(out_valid), 32'h1);
    end

    // ptr=1 now; take ch2 to move ptr to 3, then wrap and skip
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0101;
    #1;
    chk("wrap_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("wrap_src", 32'(out_src), 32'h0);
    chk("skip_rdy", 32'(in_ready), 32'h4);
    tick();
    chk("skip_src", 32'(out_src), 32'h2);

    // backpressure: hold 0x1234 from ch1 for 5 stalled cycles
    in_valid = 4'b0010;
    in_data[1*W +: W] = 32'h1234;
    tick();
    chk("bp_load", out_data, 32'h1234);
    out_ready = 0;
    in_data[1*W +: W] = 32'h5678;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", 32'(in_ready), 32'h0);
      tick();
      chk("bp_hold", out_data, 32'h1234);
      chk("bp_val", 32'(out_valid), 32'h1);
    end
    out_ready = 1;
    #1;
    chk("bp_rel", 32'(in_ready), 32'h2);
    tick();
    chk("bp_next", out_data, 32'h5678);

    // fixed priority: ch1 every cycle, ptr (=2) untouched
    set_a_data();
    fixed_pri = 1;
    in_valid  = 4'b1110;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fx_rdy", 32'(in_ready), 32'h2);
      tick();
      chk("fx_src", 32'(out_src), 32'h1);
    end
    fixed_pri = 0;
    #1;
    chk("fx_resume", 32'(in_ready), 32'h4);
    tick();
    chk("fx_rsrc", 32'(out_src), 32'h2);

    // reset while holding a word from ch2
    reset = 1;
    in_valid = 4'b1111;
    #1;
    chk("mrst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("mrst_val", 32'(out_valid), 32'h0);
    chk("mrst_src", 32'(out_src), 32'h0);
    reset = 0;
    #1;
    chk("mrst_ptr", 32'(in_ready), 32'h1);
    tick();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = C'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) fixed_pri = ~fixed_pri;
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < C; i++)
        in_data[i*W +: W] = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
